register_update_reader: RTL and testbench
=========================================

Name: register_update_reader

Overview:
- Read-side companion for the write-enabled data registers in the VT52 datapath, e.g. the cursor row/column and character latches.
- Snoops a register's write strobe and write data, and captures each accepted update into a 2-entry queue.
- Presents queued updates to a downstream consumer (renderer, host status path) over a valid/ready handshake.
- Optionally suppresses writes that do not change the value, and reports lost updates through a sticky flag and a saturating counter.

Parameters:
- SIZE, 8, width of the snooped register data.
- CHANGED_ONLY, 0, 1 = accept a write only when wdata differs from the last accepted value.
- CNT_W, 4, width of the overrun counter.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- wen  in  1  write strobe of the snooped register.
- wdata  in  SIZE  write data of the snooped register.
- rd_valid  out  1  head entry available.
- rd_data  out  SIZE  head entry value.
- rd_ready  in  1  consumer accepts head entry.
- last_value  out  SIZE  mirror of the most recent write; equals what the snooped register holds.
- overrun  out  1  sticky; at least one update was coalesced.
- overrun_cnt  out  CNT_W  number of coalesced updates, saturating.
- clr_overrun  in  1  synchronous clear of overrun and overrun_cnt.

Behaviour:
- Reset (asynchronous, reset_n low):
  - queue empty; rd_valid=0; rd_data=0; last_value=0.
  - overrun=0; overrun_cnt=0.
  - Reset asserted mid-transfer discards all queued entries immediately, with no handshake completion.
- Write mirror: last_value <= wdata on every clk edge with wen=1, regardless of CHANGED_ONLY or queue state.
- Accept rule, evaluated per cycle with wen=1:
  - CHANGED_ONLY=0: every write is accepted.
  - CHANGED_ONLY=1: the write is accepted only if wdata != last_value (the pre-edge value).
  - Post-reset, last_value=0, so writing 0 first with CHANGED_ONLY=1 is suppressed.
- Queue: 2 entries, head/tail pointers plus a count (0..2).
  - An accepted write is enqueued at the tail.
  - A pop occurs when rd_valid & rd_ready.
- Output timing:
  - rd_valid and rd_data are registered.
  - Latency is 1 cycle: a write accepted at edge N gives rd_valid=1 after edge N when the queue was empty.
  - rd_data is stable while rd_valid=1 and rd_ready=0.
- Simultaneous accepted write and pop:
  - count 1: count stays 1; the head becomes the new value.
  - count 2: pop the head, enqueue the new value; count stays 2; no overrun.
- Full (count=2) with an accepted write and no pop:
  - coalesce by overwriting the tail entry with wdata (latest value wins); the head is never overwritten.
  - overrun <= 1; overrun_cnt increments, saturating at 2^CNT_W-1.
- Empty with rd_ready=1: no effect.
- clr_overrun:
  - clears overrun and overrun_cnt at the edge.
  - If a coalesce occurs in the same cycle, the result is overrun=1 and overrun_cnt=1 (the event wins over the clear).
- States (count): EMPTY -> ONE on accept; ONE -> TWO on accept without pop; ONE -> EMPTY on pop without accept; TWO -> ONE on pop without accept; TWO -> TWO on coalesce or on pop+accept.
- Pointers: 1-bit head/tail, wrapping modulo 2.

Test Plan:
- Reset, then wen=1 wdata=8'h41 for one cycle with rd_ready=0 -> next cycle rd_valid=1, rd_data=8'h41, last_value=8'h41; the value holds until rd_ready=1, after which rd_valid=0 the cycle following the pop.
- Writes 8'h10, 8'h11, 8'h12 on consecutive cycles with rd_ready=0 -> queue holds 10, 12; overrun=1; overrun_cnt=1; pops return 8'h10 then 8'h12.
- CHANGED_ONLY=1: writes 8'h05, 8'h05, 8'h06, then 8'h00 right after reset -> the 8'h00 is suppressed, the duplicate 8'h05 is suppressed, and the consumer sees only 8'h05 and 8'h06.
- Queue full (8'h20, 8'h21), then rd_ready=1 and a write of 8'h22 in the same cycle -> no overrun; subsequent pops return 8'h21 then 8'h22.
- CNT_W=4 with 20 coalescing writes while full -> overrun_cnt=15 (saturated); clr_overrun together with one further coalesce -> overrun_cnt=1, overrun=1.
- Assert reset_n low asynchronously while rd_valid=1 with 2 entries queued -> rd_valid=0, overrun=0, last_value=0 immediately, without waiting for a clk edge; the first write after release behaves as in scenario 1.

Source files
------------

// File: rtl/register_update_reader.sv
// Snoops a register's write port and queues accepted updates (2 deep) for a
// valid/ready consumer; coalesces into the tail entry when full and counts the loss.
module register_update_reader #(
  parameter int SIZE         = 8,
  parameter bit CHANGED_ONLY = 1'b0,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wen,
  input  logic [SIZE-1:0]  wdata,
  output logic             rd_valid,
  output logic [SIZE-1:0]  rd_data,
  input  logic             rd_ready,
  output logic [SIZE-1:0]  last_value,
  output logic             overrun,
  output logic [CNT_W-1:0] overrun_cnt,
  input  logic             clr_overrun
);

  // state | meaning
  // EMPTY | no entries queued, rd_valid=0
  // ONE   | one entry queued at head
  // TWO   | full; a further accept without pop coalesces into the tail entry
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t          state;
  state_t          state_n;
  logic [SIZE-1:0] mem   [2];
  logic [SIZE-1:0] mem_n [2];
  logic            head;
  logic            head_n;
  logic            tail;
  logic            accept;
  logic            pop;
  logic            push;
  logic            coalesce;

  always_comb begin
    accept   = wen & ((CHANGED_ONLY == 1'b0) | (wdata != last_value));
    pop      = rd_valid & rd_ready;
    push     = accept & ((state != TWO) | pop);
    coalesce = accept & (state == TWO) & ~pop;

    mem_n[0] = mem[0];
    mem_n[1] = mem[1];
    // tail points at the next free slot, so the newest entry lives at ~tail
    if (push)
      mem_n[tail] = wdata;
    else if (coalesce)
      mem_n[~tail] = wdata;

    head_n  = head ^ pop;
    state_n = state;
    case (state)
      EMPTY: if (push) state_n = ONE;
      ONE: begin
        if (push && !pop)      state_n = TWO;
        else if (pop && !push) state_n = EMPTY;
      end
      TWO: if (pop && !push) state_n = ONE;
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= EMPTY;
      mem[0]      <= '0;
      mem[1]      <= '0;
      head        <= 1'b0;
      tail        <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      last_value  <= '0;
      overrun     <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      state    <= state_n;
      mem[0]   <= mem_n[0];
      mem[1]   <= mem_n[1];
      head     <= head_n;
      tail     <= tail ^ push;
      rd_valid <= (state_n != EMPTY);
      rd_data  <= mem_n[head_n];

      if (wen)
        last_value <= wdata;

      // a coalesce in the same cycle as a clear leaves exactly one event recorded
      if (coalesce) begin
        overrun <= 1'b1;
        if (clr_overrun)
          overrun_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
        else if (overrun_cnt != CNT_MAX)
          overrun_cnt <= overrun_cnt + 1'b1;
      end else if (clr_overrun) begin
        overrun     <= 1'b0;
        overrun_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_register_update_reader.sv
// Bench for register_update_reader: two instances (CHANGED_ONLY=0/1) checked
// against a shifting-array queue model, directed tables, and random traffic.
module tb_register_update_reader;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wen = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       rd_ready = 1'b0;
  logic       clr_overrun = 1'b0;

  logic       va, vc, oa, oc;
  logic [7:0] da, dc, la, lc;
  logic [3:0] ca, cc;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  register_update_reader #(.SIZE(8), .CHANGED_ONLY(1'b0), .CNT_W(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .wen(wen), .wdata(wdata),
    .rd_valid(va), .rd_data(da), .rd_ready(rd_ready),
    .last_value(la), .overrun(oa), .overrun_cnt(ca), .clr_overrun(clr_overrun)
  );

  register_update_reader #(.SIZE(8), .CHANGED_ONLY(1'b1), .CNT_W(4)) dut_c (
    .clk(clk), .reset_n(reset_n), .wen(wen), .wdata(wdata),
    .rd_valid(vc), .rd_data(dc), .rd_ready(rd_ready),
    .last_value(lc), .overrun(oc), .overrun_cnt(cc), .clr_overrun(clr_overrun)
  );

  // reference model: index 0 = CHANGED_ONLY=0, index 1 = CHANGED_ONLY=1; entry 0 is the head
  logic [7:0] m_e [2][2];
  int         m_n [2];
  logic [7:0] m_last [2];
  bit         m_ovr [2];
  int         m_cnt [2];

  typedef struct {
    bit         w;
    logic [7:0] d;
    bit         r;
    bit         c;
    bit         ev;
    logic [7:0] ed;
    logic [7:0] el;
    bit         eo;
    int         ec;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_e[k][0] = 8'h00;
      m_e[k][1] = 8'h00;
      m_n[k] = 0;
      m_last[k] = 8'h00;
      m_ovr[k] = 1'b0;
      m_cnt[k] = 0;
    end
  endtask

  task automatic model_step(input bit w, input logic [7:0] d, input bit r, input bit c);
    for (int k = 0; k < 2; k++) begin
      bit acc, take, coal;
      acc  = w && (k == 0 || d != m_last[k]);
      take = r && (m_n[k] > 0);
      coal = 1'b0;
      if (take) begin
        m_e[k][0] = m_e[k][1];
        m_n[k]--;
      end
      if (acc) begin
        if (m_n[k] < 2) begin
          m_e[k][m_n[k]] = d;
          m_n[k]++;
        end else begin
          m_e[k][1] = d;
          coal = 1'b1;
        end
      end
      if (coal) begin
        m_ovr[k] = 1'b1;
        m_cnt[k] = c ? 1 : ((m_cnt[k] < 15) ? m_cnt[k] + 1 : 15);
      end else if (c) begin
        m_ovr[k] = 1'b0;
        m_cnt[k] = 0;
      end
      if (w) m_last[k] = d;
    end
  endtask

  task automatic check_model();
    chk("mdl_a_valid", va, (m_n[0] > 0));
    if (m_n[0] > 0) chk("mdl_a_data", da, m_e[0][0]);
    chk("mdl_a_last", la, m_last[0]);
    chk("mdl_a_ovr", oa, m_ovr[0]);
    chk("mdl_a_cnt", ca, m_cnt[0]);
    chk("mdl_c_valid", vc, (m_n[1] > 0));
    if (m_n[1] > 0) chk("mdl_c_data", dc, m_e[1][0]);
    chk("mdl_c_last", lc, m_last[1]);
    chk("mdl_c_ovr", oc, m_ovr[1]);
    chk("mdl_c_cnt", cc, m_cnt[1]);
  endtask

  task automatic step(input bit w, input logic [7:0] d, input bit r, input bit c);
    wen = w;
    wdata = d;
    rd_ready = r;
    clr_overrun = c;
    model_step(w, d, r, c);
    @(posedge clk);
    #1;
    check_model();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // fields: wen, wdata, rd_ready, clr, exp valid, exp data, exp last, exp overrun, exp cnt (dut_a)
    tbl[0]  = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b1, 8'h41, 8'h41, 1'b0, 0};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h41, 8'h41, 1'b0, 0};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h41, 8'h41, 1'b0, 0};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h41, 1'b0, 0};
    tbl[4]  = '{1'b1, 8'h10, 1'b0, 1'b0, 1'b1, 8'h10, 8'h10, 1'b0, 0};
    tbl[5]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 8'h10, 8'h11, 1'b0, 0};
    tbl[6]  = '{1'b1, 8'h12, 1'b0, 1'b0, 1'b1, 8'h10, 8'h12, 1'b1, 1};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h12, 8'h12, 1'b1, 1};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h12, 1'b1, 1};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h12, 1'b0, 0};
    tbl[10] = '{1'b1, 8'h20, 1'b0, 1'b0, 1'b1, 8'h20, 8'h20, 1'b0, 0};
    tbl[11] = '{1'b1, 8'h21, 1'b0, 1'b0, 1'b1, 8'h20, 8'h21, 1'b0, 0};
    tbl[12] = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 8'h21, 8'h22, 1'b0, 0};
    tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22, 8'h22, 1'b0, 0};
    tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h22, 1'b0, 0};
    tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h22, 1'b0, 0};

    model_reset();
    #12;
    chk("reset_valid", va, 0);
    chk("reset_data", da, 0);
    chk("reset_last", la, 0);
    chk("reset_ovr", oa, 0);
    chk("reset_cnt", ca, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].w, tbl[i].d, tbl[i].r, tbl[i].c);
      chk($sformatf("tbl%0d_valid", i), va, tbl[i].ev);
      if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), da, tbl[i].ed);
      chk($sformatf("tbl%0d_last", i), la, tbl[i].el);
      chk($sformatf("tbl%0d_ovr", i), oa, tbl[i].eo);
      chk($sformatf("tbl%0d_cnt", i), ca, tbl[i].ec);
    end

    // saturation, then clear together with a coalesce
    step(1'b1, 8'h30, 1'b0, 1'b0);
    step(1'b1, 8'h31, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
    chk("sat_cnt", ca, 15);
    chk("sat_ovr", oa, 1);
    chk("sat_head", da, 8'h30);
    step(1'b1, 8'h55, 1'b0, 1'b1);
    chk("clr_coal_cnt", ca, 1);
    chk("clr_coal_ovr", oa, 1);

    // asynchronous reset with two entries queued
    chk("pre_rst_valid", va, 1);
    wen = 1'b0;
    rd_ready = 1'b0;
    clr_overrun = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", va, 0);
    chk("async_rst_ovr", oa, 0);
    chk("async_rst_last", la, 0);
    chk("async_rst_cnt", ca, 0);
    model_reset();
    @(posedge clk);
    #1;
    check_model();
    reset_n = 1'b1;

    // first write after release; CHANGED_ONLY suppression on dut_c
    step(1'b1, 8'h00, 1'b0, 1'b0);
    chk("post_rst_a_valid", va, 1);
    chk("post_rst_a_data", da, 8'h00);
    chk("co_zero_suppressed", vc, 0);
    step(1'b1, 8'h05, 1'b0, 1'b0);
    chk("co_first_valid", vc, 1);
    chk("co_first_data", dc, 8'h05);
    step(1'b1, 8'h05, 1'b0, 1'b0);
    step(1'b1, 8'h06, 1'b0, 1'b0);
    chk("co_no_overrun", oc, 0);
    chk("co_head", dc, 8'h05);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("co_second_data", dc, 8'h06);
    chk("co_second_valid", vc, 1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("co_drained", vc, 0);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 1) == 1), 8'($urandom_range(0, 3)),
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 15) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
